// File: rtl/jtag_host.sv
// jtag_host
//   JTAG initiator running from the system clock. Takes one command at a time
//   over a valid/ready channel (TAP reset, IR shift, DR shift), bit-bangs the
//   TAP pins with a divided tck, and returns the tdo bits it captured on a
//   valid/ready response channel.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   cmd_valid  command present
//   cmd_ready  command accepted when cmd_valid & cmd_ready
//   cmd_type   0 = TAP reset, 1 = shift IR, 2 = shift DR, 3 = reserved (error)
//   cmd_len    number of bits to shift (1..MAX_LEN)
//   cmd_data   bits to shift out on tdi, LSB first
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  response consumed when rsp_valid & rsp_ready
//   rsp_data   captured tdo bits, bit i = i-th bit shifted, upper bits zero
//   rsp_err    command rejected (bad type or bad length)
//   tck/tms/tdi  JTAG pins towards the target
//   tdo        JTAG data from the target

module jtag_host #(
  parameter int MAX_LEN = 64,
  parameter int CLK_DIV = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_type,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [MAX_LEN-1:0]           cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [MAX_LEN-1:0]           rsp_data,
  output logic                         rsp_err,
  output logic                         tck,
  output logic                         tms,
  output logic                         tdi,
  input  logic                         tdo
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  // The pulse counter must also hold the fixed sequence lengths (up to 6).
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, RST, HDR, SHIFT, TAIL, DONE} stateT;

  stateT              state;
  logic [DIV_W-1:0]   divCnt;
  logic [CNT_W-1:0]   bitCnt;
  logic               isIr;
  logic               isTapReset;
  logic               synced;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] data;

  // tms value for pulse 'cnt' of a given phase.
  function automatic logic tmsFor(stateT st, logic [CNT_W-1:0] cnt, logic ir,
                                  logic [LEN_W-1:0] n);
    case (st)
      RST:     return cnt != CNT_W'(5);
      HDR:     return ir ? (cnt < CNT_W'(2)) : (cnt == '0);
      SHIFT:   return cnt == CNT_W'(n) - 1'b1;
      TAIL:    return cnt == '0;
      default: return 1'b0;
    endcase
  endfunction

  // tdi carries payload only while shifting; it is parked low otherwise.
  function automatic logic tdiFor(stateT st, logic [CNT_W-1:0] cnt,
                                  logic [MAX_LEN-1:0] d);
    logic [MAX_LEN-1:0] s;
    s = d >> cnt;
    return (st == SHIFT) && s[0];
  endfunction

  function automatic logic [CNT_W-1:0] pulsesIn(stateT st, logic ir,
                                                logic [LEN_W-1:0] n);
    case (st)
      RST:     return CNT_W'(6);
      HDR:     return ir ? CNT_W'(4) : CNT_W'(3);
      SHIFT:   return CNT_W'(n);
      TAIL:    return CNT_W'(2);
      default: return CNT_W'(1);
    endcase
  endfunction

  function automatic stateT nextPhase(stateT st, logic tapReset);
    case (st)
      RST:     return tapReset ? DONE : HDR;
      HDR:     return SHIFT;
      SHIFT:   return TAIL;
      default: return DONE;
    endcase
  endfunction

  logic             cmdBad;
  stateT            startPhase;
  stateT            afterPhase;
  logic [CNT_W-1:0] nextCnt;
  logic             lastPulse;
  logic             divWrap;

  assign cmdBad     = (cmd_type == 2'd3) || (cmd_len == '0) ||
                      (cmd_len > LEN_W'(MAX_LEN));
  // A shift issued before the TAP is known to be in Idle gets a reset first.
  assign startPhase = ((cmd_type == 2'd0) || !synced) ? RST : HDR;
  assign afterPhase = nextPhase(state, isTapReset);
  assign nextCnt    = bitCnt + 1'b1;
  assign lastPulse  = (bitCnt == pulsesIn(state, isIr, len) - 1'b1);
  assign divWrap    = (divCnt == DIV_W'(CLK_DIV - 1));

  // Command sequencer and tck generator. tck toggles every CLK_DIV clocks in
  // the active phases; tdo is captured on the rising toggle, and tms/tdi for
  // the next pulse are loaded on the falling toggle so they are stable for a
  // full half-period before the target samples them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      divCnt     <= '0;
      bitCnt     <= '0;
      isIr       <= 1'b0;
      isTapReset <= 1'b0;
      synced     <= 1'b0;
      len        <= '0;
      data       <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      tck        <= 1'b0;
      tms        <= 1'b1;
      tdi        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            rsp_data   <= '0;
            divCnt     <= '0;
            bitCnt     <= '0;
            isIr       <= (cmd_type == 2'd1);
            isTapReset <= (cmd_type == 2'd0);
            len        <= cmd_len;
            data       <= cmd_data;
            if (cmdBad) begin
              rsp_err <= 1'b1;
              state   <= DONE;
              tms     <= 1'b0;
              tdi     <= 1'b0;
            end else begin
              rsp_err <= 1'b0;
              state   <= startPhase;
              tms     <= tmsFor(startPhase, '0, cmd_type == 2'd1, cmd_len);
              tdi     <= tdiFor(startPhase, '0, cmd_data);
            end
          end
        end
        DONE: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          if (!divWrap) begin
            divCnt <= divCnt + 1'b1;
          end else begin
            divCnt <= '0;
            if (!tck) begin
              tck <= 1'b1;
              if (state == SHIFT)
                rsp_data <= rsp_data | (MAX_LEN'(tdo) << bitCnt);
            end else begin
              tck <= 1'b0;
              if (lastPulse) begin
                bitCnt <= '0;
                state  <= afterPhase;
                tms    <= tmsFor(afterPhase, '0, isIr, len);
                tdi    <= tdiFor(afterPhase, '0, data);
                if (state == RST)
                  synced <= 1'b1;
              end else begin
                bitCnt <= nextCnt;
                tms    <= tmsFor(state, nextCnt, isIr, len);
                tdi    <= tdiFor(state, nextCnt, data);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host
//   Drives jtag_host against a behavioural TAP (4-bit IR, 1-bit BYPASS) and
//   checks pulse counts, tms/tdi sequences, captured data and error handling
//   against a reference model built from the command rules.

module tb_jtag_host;

  localparam int MAX_LEN = 64;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               tck, tms, tdi;
  logic               tdo = 1'b0;

  int nCompared = 0;
  int nMismatch = 0;

  jtag_host #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // Behavioural IEEE 1149.1 TAP target
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDDR,
                    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPDIR} tapStateT;

  tapStateT   tapState = SHDR;
  logic [3:0] tapIr = 4'h0;
  logic [3:0] irSh = 4'h0;
  logic       byp = 1'b0;

  function automatic tapStateT tapNext(tapStateT s, logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDDR : PSDR;
      PSDR:    return m ? EX2DR : PSDR;
      EX2DR:   return m ? UPDDR : SHDR;
      UPDDR:   return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPDIR : PSIR;
      PSIR:    return m ? EX2IR : PSIR;
      EX2IR:   return m ? UPDIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  // Target register actions and state step on the rising tck edge
  always @(posedge tck) begin
    case (tapState)
      CAPIR:   irSh <= 4'b0001;
      SHIR:    irSh <= {tdi, irSh[3:1]};
      UPDIR:   tapIr <= irSh;
      CAPDR:   byp <= 1'b0;
      SHDR:    byp <= tdi;
      default: ;
    endcase
    tapState <= tapNext(tapState, tms);
  end

  // Target drives tdo on the falling edge while in a shift state
  always @(negedge tck)
    tdo <= (tapState == SHIR) ? irSh[0] : (tapState == SHDR) ? byp : 1'b0;

  // Pin monitor: what the target sees on every rising tck
  int   pulseCount = 0;
  logic tmsQ[$];
  logic tdiQ[$];

  always @(posedge tck) begin
    pulseCount++;
    tmsQ.push_back(tms);
    tdiQ.push_back(tdi);
  end

  // Reference model
  bit                 modelSynced = 1'b0;
  logic [127:0]       wantTms, wantTdi;
  int                 wantPulses;
  logic [MAX_LEN-1:0] wantRsp;
  logic [3:0]         wantIr;

  task automatic buildExpect(input logic [1:0] t, input int n,
                             input logic [MAX_LEN-1:0] d);
    bit               pre;
    int               k;
    logic [MAX_LEN+3:0] comb;
    pre = (t == 2'd0) || !modelSynced;
    wantTms = '0;
    wantTdi = '0;
    wantRsp = '0;
    wantIr  = '0;
    k = 0;
    if (pre) begin
      for (int i = 0; i < 6; i++) begin
        wantTms[k] = (i < 5);
        k++;
      end
    end
    if (t != 2'd0) begin
      if (t == 2'd1) begin
        wantTms[k] = 1'b1;
        wantTms[k+1] = 1'b1;
        k += 4;
      end else begin
        wantTms[k] = 1'b1;
        k += 3;
      end
      for (int i = 0; i < n; i++) begin
        wantTms[k] = (i == n - 1);
        wantTdi[k] = d[i];
        k++;
      end
      wantTms[k] = 1'b1;
      k += 2;
      comb = (t == 2'd1) ? {d, 4'b0001} : {3'b000, d, 1'b0};
      for (int i = 0; i < n; i++)
        wantRsp[i] = comb[i];
      wantIr = comb[n +: 4];
    end
    wantPulses = k;
  endtask

  // Stimulus drivers (collect only, no checking)
  bit                 gotValid;
  int                 gotPulses;
  logic [127:0]       gotTms, gotTdi;
  logic [MAX_LEN-1:0] gotRsp;
  logic               gotErr;

  task automatic sendCmd(input logic [1:0] t, input logic [LEN_W-1:0] n,
                         input logic [MAX_LEN-1:0] d);
    int w;
    @(negedge clk);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    pulseCount = 0;
    tmsQ.delete();
    tdiQ.delete();
    cmd_type  = t;
    cmd_len   = n;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_len   = LEN_W'($urandom);
    cmd_data  = MAX_LEN'({$urandom, $urandom});
  endtask

  task automatic waitRsp();
    int w;
    w = 0;
    while (rsp_valid !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    gotValid  = (rsp_valid === 1'b1);
    gotRsp    = rsp_data;
    gotErr    = rsp_err;
    gotPulses = pulseCount;
    gotTms    = '0;
    gotTdi    = '0;
    foreach (tmsQ[i]) if (i < 128) gotTms[i] = tmsQ[i];
    foreach (tdiQ[i]) if (i < 128) gotTdi[i] = tdiQ[i];
  endtask

  task automatic consumeRsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b0;
    #12;
    nCompared++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, rsp_err} !== 6'b010000) begin
      nMismatch++;
      $display("[TB] FAIL resetPins: got %b want 010000",
               {tck, tms, tdi, cmd_ready, rsp_valid, rsp_err});
    end
    nCompared++;
    if (rsp_data !== '0) begin
      nMismatch++;
      $display("[TB] FAIL resetData: got %h want 0", rsp_data);
    end
    @(negedge clk);
    reset = 1'b1;
    modelSynced = 1'b0;
    repeat (2) @(negedge clk);
    nCompared++;
    if (cmd_ready !== 1'b1) begin
      nMismatch++;
      $display("[TB] FAIL readyAfterReset: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_tap_reset();
    buildExpect(2'd0, 0, '0);
    sendCmd(2'd0, LEN_W'(5), MAX_LEN'(64'h1234));
    waitRsp();
    consumeRsp();
    nCompared++;
    if (!gotValid || gotPulses !== 6 || wantPulses !== 6) begin
      nMismatch++;
      $display("[TB] FAIL tapResetPulses: got %0d (valid %b) want 6", gotPulses, gotValid);
    end
    nCompared++;
    if (gotTms !== wantTms) begin
      nMismatch++;
      $display("[TB] FAIL tapResetTms: got %h want %h", gotTms, wantTms);
    end
    nCompared++;
    if (gotRsp !== '0 || gotErr !== 1'b0) begin
      nMismatch++;
      $display("[TB] FAIL tapResetRsp: got %h err %b want 0 err 0", gotRsp, gotErr);
    end
    nCompared++;
    if (tapState !== RTI) begin
      nMismatch++;
      $display("[TB] FAIL tapResetState: got %0d want %0d", tapState, RTI);
    end
    modelSynced = 1'b1;
  endtask

  task automatic test_dr_fixed();
    buildExpect(2'd2, 8, MAX_LEN'(8'hA5));
    sendCmd(2'd2, LEN_W'(8), MAX_LEN'(8'hA5));
    waitRsp();
    consumeRsp();
    nCompared++;
    if (!gotValid || gotPulses !== 13) begin
      nMismatch++;
      $display("[TB] FAIL drPulses: got %0d (valid %b) want 13", gotPulses, gotValid);
    end
    nCompared++;
    if (gotTms !== wantTms || gotTdi !== wantTdi) begin
      nMismatch++;
      $display("[TB] FAIL drPins: tms %h tdi %h want tms %h tdi %h",
               gotTms, gotTdi, wantTms, wantTdi);
    end
    nCompared++;
    if (gotRsp !== MAX_LEN'(8'h4A) || gotErr !== 1'b0) begin
      nMismatch++;
      $display("[TB] FAIL drRsp: got %h err %b want 4a err 0", gotRsp, gotErr);
    end
    nCompared++;
    if (tapState !== RTI) begin
      nMismatch++;
      $display("[TB] FAIL drState: got %0d want %0d", tapState, RTI);
    end
  endtask

  task automatic test_ir_after_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    modelSynced = 1'b0;
    buildExpect(2'd1, 4, MAX_LEN'(4'hF));
    sendCmd(2'd1, LEN_W'(4), MAX_LEN'(4'hF));
    waitRsp();
    consumeRsp();
    nCompared++;
    if (!gotValid || gotPulses !== 16) begin
      nMismatch++;
      $display("[TB] FAIL irPulses: got %0d (valid %b) want 16", gotPulses, gotValid);
    end
    nCompared++;
    if (gotTms !== wantTms) begin
      nMismatch++;
      $display("[TB] FAIL irTms: got %h want %h", gotTms, wantTms);
    end
    nCompared++;
    if (gotRsp !== MAX_LEN'(4'b0001) || tapIr !== 4'hF) begin
      nMismatch++;
      $display("[TB] FAIL irResult: rsp %h ir %h want rsp 1 ir f", gotRsp, tapIr);
    end
    modelSynced = 1'b1;
  endtask

  task automatic test_errors();
    logic [1:0]       t;
    logic [LEN_W-1:0] n;
    bit               readyLow;
    for (int c = 0; c < 3; c++) begin
      t = (c == 2) ? 2'd3 : ((c == 0) ? 2'd2 : 2'd1);
      n = (c == 0) ? LEN_W'(0) : ((c == 1) ? LEN_W'(MAX_LEN + 1) : LEN_W'(8));
      sendCmd(t, n, MAX_LEN'({$urandom, $urandom}));
      @(posedge clk);
      #1;
      nCompared++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
        nMismatch++;
        $display("[TB] FAIL err%0dRsp: valid %b err %b data %h want 1 1 0",
                 c, rsp_valid, rsp_err, rsp_data);
      end
      readyLow = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (cmd_ready !== 1'b0) readyLow = 1'b0;
      end
      nCompared++;
      if (readyLow !== 1'b1) begin
        nMismatch++;
        $display("[TB] FAIL err%0dReady: got high want low while response pending", c);
      end
      consumeRsp();
      nCompared++;
      if (pulseCount !== 0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        nMismatch++;
        $display("[TB] FAIL err%0dAfter: pulses %0d ready %b valid %b want 0 1 0",
                 c, pulseCount, cmd_ready, rsp_valid);
      end
    end
  endtask

  task automatic test_hold();
    logic [MAX_LEN-1:0] d;
    int                 n;
    d = MAX_LEN'({$urandom, $urandom});
    n = $urandom_range(1, MAX_LEN);
    buildExpect(2'd2, n, d);
    sendCmd(2'd2, LEN_W'(n), d);
    // rsp_ready while no response is present must be ignored
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rsp_ready = 1'b0;
    waitRsp();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nCompared++;
      if (rsp_valid !== 1'b1 || rsp_data !== wantRsp || cmd_ready !== 1'b0) begin
        nMismatch++;
        $display("[TB] FAIL hold%0d: valid %b data %h ready %b want 1 %h 0",
                 i, rsp_valid, rsp_data, cmd_ready, wantRsp);
      end
    end
    consumeRsp();
  endtask

  task automatic test_random();
    logic [1:0]         t;
    int                 n;
    logic [MAX_LEN-1:0] d;
    for (int it = 0; it < 12; it++) begin
      t = 2'($urandom_range(1, 2));
      n = (it == 0) ? 1 : ((it == 1) ? MAX_LEN : $urandom_range(1, MAX_LEN));
      d = MAX_LEN'({$urandom, $urandom});
      buildExpect(t, n, d);
      sendCmd(t, LEN_W'(n), d);
      waitRsp();
      consumeRsp();
      nCompared++;
      if (!gotValid || gotPulses !== wantPulses) begin
        nMismatch++;
        $display("[TB] FAIL rnd%0dPulses: got %0d (valid %b) want %0d",
                 it, gotPulses, gotValid, wantPulses);
      end
      nCompared++;
      if (gotTms !== wantTms || gotTdi !== wantTdi) begin
        nMismatch++;
        $display("[TB] FAIL rnd%0dPins: tms %h tdi %h want tms %h tdi %h",
                 it, gotTms, gotTdi, wantTms, wantTdi);
      end
      nCompared++;
      if (gotRsp !== wantRsp || gotErr !== 1'b0) begin
        nMismatch++;
        $display("[TB] FAIL rnd%0dRsp: got %h err %b want %h err 0", it, gotRsp, gotErr, wantRsp);
      end
      nCompared++;
      if (tapState !== RTI || (t == 2'd1 && tapIr !== wantIr)) begin
        nMismatch++;
        $display("[TB] FAIL rnd%0dTap: state %0d ir %h want %0d ir %h",
                 it, tapState, tapIr, RTI, wantIr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int                 w;
    logic [MAX_LEN-1:0] d;
    sendCmd(2'd2, LEN_W'(32), MAX_LEN'({$urandom, $urandom}));
    w = 0;
    while (pulseCount < 7 && w < 500) begin
      @(negedge clk);
      w++;
    end
    nCompared++;
    if (pulseCount !== 7) begin
      nMismatch++;
      $display("[TB] FAIL midReach: got %0d pulses want 7", pulseCount);
    end
    reset = 1'b0;
    #1;
    nCompared++;
    if ({tck, tms, rsp_valid, cmd_ready} !== 4'b0100) begin
      nMismatch++;
      $display("[TB] FAIL midReset: got %b want 0100", {tck, tms, rsp_valid, cmd_ready});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    modelSynced = 1'b0;
    d = MAX_LEN'({$urandom, $urandom});
    buildExpect(2'd2, 16, d);
    sendCmd(2'd2, LEN_W'(16), d);
    waitRsp();
    consumeRsp();
    nCompared++;
    if (!gotValid || gotPulses !== 27 || gotTms !== wantTms) begin
      nMismatch++;
      $display("[TB] FAIL postReset: pulses %0d tms %h want 27 tms %h",
               gotPulses, gotTms, wantTms);
    end
    nCompared++;
    if (gotRsp !== wantRsp || tapState !== RTI) begin
      nMismatch++;
      $display("[TB] FAIL postResetRsp: got %h state %0d want %h state %0d",
               gotRsp, tapState, wantRsp, RTI);
    end
    modelSynced = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_dr_fixed();
    test_ir_after_reset();
    test_errors();
    test_hold();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
